dispatch_rename: RTL and testbench

- Dispatch stage directly downstream of the instruction queue.
- Pops one decoded instruction per cycle and allocates its ROB entry.
- Renames rd in a 32-entry register alias table (RAT) and resolves source operands from the regfile, the ROB or the CDB.
- Presents a registered operand packet to the reservation stations, snooping the CDB while the packet is held.

---
 rtl/dispatch_rename.sv | 165 ++++++++++++++++
 tb/tb_dispatch_rename.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_rename.sv
// Dispatch/rename stage: pops one instruction per cycle from the instruction queue,
// allocates its ROB entry, renames rd in the RAT and registers a resolved operand packet.
module dispatch_rename #(
   parameter int ROB_IDX_LEN = 4,
   parameter int PAYLOAD_W   = 96
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,

   input  logic                   iq_vld_i,
   output logic                   iq_rdy_o,
   input  logic [4:0]             iq_rs1_i,
   input  logic [4:0]             iq_rs2_i,
   input  logic [4:0]             iq_rd_i,
   input  logic                   iq_use_rs1_i,
   input  logic                   iq_use_rs2_i,
   input  logic                   iq_wr_rd_i,
   input  logic [PAYLOAD_W-1:0]   iq_payload_i,

   input  logic                   rob_alloc_rdy_i,
   input  logic [ROB_IDX_LEN-1:0] rob_alloc_tag_i,
   output logic                   rob_alloc_vld_o,
   output logic [4:0]             rob_alloc_rd_o,

   output logic [4:0]             rf_rs1_idx_o,
   output logic [4:0]             rf_rs2_idx_o,
   input  logic [31:0]            rf_rs1_data_i,
   input  logic [31:0]            rf_rs2_data_i,

   output logic [ROB_IDX_LEN-1:0] rob_rd1_tag_o,
   output logic [ROB_IDX_LEN-1:0] rob_rd2_tag_o,
   input  logic                   rob_rd1_rdy_i,
   input  logic                   rob_rd2_rdy_i,
   input  logic [31:0]            rob_rd1_data_i,
   input  logic [31:0]            rob_rd2_data_i,

   input  logic                   cdb_vld_i,
   input  logic [ROB_IDX_LEN-1:0] cdb_tag_i,
   input  logic [31:0]            cdb_data_i,

   input  logic                   commit_vld_i,
   input  logic [ROB_IDX_LEN-1:0] commit_tag_i,
   input  logic [4:0]             commit_rd_i,

   output logic                   rs_vld_o,
   input  logic                   rs_rdy_i,
   output logic [ROB_IDX_LEN-1:0] rs_tag_o,
   output logic [31:0]            rs_v1_o,
   output logic [31:0]            rs_v2_o,
   output logic [ROB_IDX_LEN-1:0] rs_q1_o,
   output logic [ROB_IDX_LEN-1:0] rs_q2_o,
   output logic                   rs_p1_o,
   output logic                   rs_p2_o,
   output logic [PAYLOAD_W-1:0]   rs_payload_o
);

   logic [31:0]            busy;
   logic [ROB_IDX_LEN-1:0] tag [32];
   logic                   accept;

   logic [31:0]            v1_res, v2_res;
   logic                   p1_res, p2_res;
   logic [ROB_IDX_LEN-1:0] q1_res, q2_res;

   assign iq_rdy_o        = ~rst & rob_alloc_rdy_i & (~rs_vld_o | rs_rdy_i) & ~flush_i;
   assign accept          = iq_vld_i & iq_rdy_o;
   assign rob_alloc_vld_o = accept;
   assign rob_alloc_rd_o  = iq_wr_rd_i ? iq_rd_i : 5'd0;

   assign rf_rs1_idx_o  = iq_rs1_i;
   assign rf_rs2_idx_o  = iq_rs2_i;
   assign rob_rd1_tag_o = tag[iq_rs1_i];
   assign rob_rd2_tag_o = tag[iq_rs2_i];

   // Priority: unused/x0, architectural value, ROB result, same-cycle CDB, pending.
   always_comb begin
      v1_res = '0;
      p1_res = 1'b0;
      q1_res = '0;
      if (iq_use_rs1_i && iq_rs1_i != 5'd0) begin
         if (!busy[iq_rs1_i])
            v1_res = rf_rs1_data_i;
         else if (rob_rd1_rdy_i)
            v1_res = rob_rd1_data_i;
         else if (cdb_vld_i && cdb_tag_i == tag[iq_rs1_i])
            v1_res = cdb_data_i;
         else begin
            p1_res = 1'b1;
            q1_res = tag[iq_rs1_i];
         end
      end
   end

   always_comb begin
      v2_res = '0;
      p2_res = 1'b0;
      q2_res = '0;
      if (iq_use_rs2_i && iq_rs2_i != 5'd0) begin
         if (!busy[iq_rs2_i])
            v2_res = rf_rs2_data_i;
         else if (rob_rd2_rdy_i)
            v2_res = rob_rd2_data_i;
         else if (cdb_vld_i && cdb_tag_i == tag[iq_rs2_i])
            v2_res = cdb_data_i;
         else begin
            p2_res = 1'b1;
            q2_res = tag[iq_rs2_i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rs_vld_o     <= 1'b0;
         rs_tag_o     <= '0;
         rs_v1_o      <= '0;
         rs_v2_o      <= '0;
         rs_q1_o      <= '0;
         rs_q2_o      <= '0;
         rs_p1_o      <= 1'b0;
         rs_p2_o      <= 1'b0;
         rs_payload_o <= '0;
      end else if (accept) begin
         rs_vld_o     <= 1'b1;
         rs_tag_o     <= rob_alloc_tag_i;
         rs_v1_o      <= v1_res;
         rs_v2_o      <= v2_res;
         rs_q1_o      <= q1_res;
         rs_q2_o      <= q2_res;
         rs_p1_o      <= p1_res;
         rs_p2_o      <= p2_res;
         rs_payload_o <= iq_payload_i;
      end else if (rs_vld_o && rs_rdy_i) begin
         rs_vld_o <= 1'b0;
      end else if (rs_vld_o && cdb_vld_i) begin
         // Held packet keeps snooping so it never misses its producer's broadcast.
         if (rs_p1_o && cdb_tag_i == rs_q1_o) begin
            rs_v1_o <= cdb_data_i;
            rs_p1_o <= 1'b0;
         end
         if (rs_p2_o && cdb_tag_i == rs_q2_o) begin
            rs_v2_o <= cdb_data_i;
            rs_p2_o <= 1'b0;
         end
      end
   end

   // Commit clear is applied first so a same-cycle rename of that rd overrides it.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         busy <= '0;
         for (int i = 0; i < 32; i++)
            tag[i] <= '0;
      end else begin
         if (commit_vld_i && busy[commit_rd_i] && tag[commit_rd_i] == commit_tag_i)
            busy[commit_rd_i] <= 1'b0;
         if (accept && iq_wr_rd_i && iq_rd_i != 5'd0) begin
            busy[iq_rd_i] <= 1'b1;
            tag[iq_rd_i]  <= rob_alloc_tag_i;
         end
      end
   end

endmodule

// File: tb/tb_dispatch_rename.sv
// Self-checking bench for dispatch_rename: a rename-table model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_dispatch_rename;

   localparam int TW = 4;
   localparam int PW = 96;

   logic          clk = 1'b0;
   logic          rst, flush_i;
   logic          iq_vld_i, iq_rdy_o;
   logic [4:0]    iq_rs1_i, iq_rs2_i, iq_rd_i;
   logic          iq_use_rs1_i, iq_use_rs2_i, iq_wr_rd_i;
   logic [PW-1:0] iq_payload_i;
   logic          rob_alloc_rdy_i;
   logic [TW-1:0] rob_alloc_tag_i;
   logic          rob_alloc_vld_o;
   logic [4:0]    rob_alloc_rd_o;
   logic [4:0]    rf_rs1_idx_o, rf_rs2_idx_o;
   logic [31:0]   rf_rs1_data_i, rf_rs2_data_i;
   logic [TW-1:0] rob_rd1_tag_o, rob_rd2_tag_o;
   logic          rob_rd1_rdy_i, rob_rd2_rdy_i;
   logic [31:0]   rob_rd1_data_i, rob_rd2_data_i;
   logic          cdb_vld_i;
   logic [TW-1:0] cdb_tag_i;
   logic [31:0]   cdb_data_i;
   logic          commit_vld_i;
   logic [TW-1:0] commit_tag_i;
   logic [4:0]    commit_rd_i;
   logic          rs_vld_o, rs_rdy_i;
   logic [TW-1:0] rs_tag_o, rs_q1_o, rs_q2_o;
   logic [31:0]   rs_v1_o, rs_v2_o;
   logic          rs_p1_o, rs_p2_o;
   logic [PW-1:0] rs_payload_o;

   int checks = 0;
   int errors = 0;

   dispatch_rename #(.ROB_IDX_LEN(TW), .PAYLOAD_W(PW)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .iq_vld_i(iq_vld_i), .iq_rdy_o(iq_rdy_o),
      .iq_rs1_i(iq_rs1_i), .iq_rs2_i(iq_rs2_i), .iq_rd_i(iq_rd_i),
      .iq_use_rs1_i(iq_use_rs1_i), .iq_use_rs2_i(iq_use_rs2_i), .iq_wr_rd_i(iq_wr_rd_i),
      .iq_payload_i(iq_payload_i),
      .rob_alloc_rdy_i(rob_alloc_rdy_i), .rob_alloc_tag_i(rob_alloc_tag_i),
      .rob_alloc_vld_o(rob_alloc_vld_o), .rob_alloc_rd_o(rob_alloc_rd_o),
      .rf_rs1_idx_o(rf_rs1_idx_o), .rf_rs2_idx_o(rf_rs2_idx_o),
      .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
      .rob_rd1_tag_o(rob_rd1_tag_o), .rob_rd2_tag_o(rob_rd2_tag_o),
      .rob_rd1_rdy_i(rob_rd1_rdy_i), .rob_rd2_rdy_i(rob_rd2_rdy_i),
      .rob_rd1_data_i(rob_rd1_data_i), .rob_rd2_data_i(rob_rd2_data_i),
      .cdb_vld_i(cdb_vld_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
      .commit_vld_i(commit_vld_i), .commit_tag_i(commit_tag_i), .commit_rd_i(commit_rd_i),
      .rs_vld_o(rs_vld_o), .rs_rdy_i(rs_rdy_i), .rs_tag_o(rs_tag_o),
      .rs_v1_o(rs_v1_o), .rs_v2_o(rs_v2_o), .rs_q1_o(rs_q1_o), .rs_q2_o(rs_q2_o),
      .rs_p1_o(rs_p1_o), .rs_p2_o(rs_p2_o), .rs_payload_o(rs_payload_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_busy [32];
   int          m_tag  [32];
   bit          m_vld;
   int          m_rtag, m_q1, m_q2;
   logic [31:0] m_v1, m_v2;
   bit          m_p1, m_p2;
   logic [PW-1:0] m_pay;

   function automatic bit exp_rdy();
      return !rst && rob_alloc_rdy_i && (!m_vld || rs_rdy_i) && !flush_i;
   endfunction

   // Operand lookup following the renaming rules, first match wins.
   task automatic lookup(input bit en, input int idx, input logic [31:0] rf, input bit rob_ok,
                         input logic [31:0] rob_val, output logic [31:0] v, output bit p,
                         output int q);
      v = 0; p = 0; q = 0;
      if (!en || idx == 0)                           v = 0;
      else if (!m_busy[idx])                         v = rf;
      else if (rob_ok)                               v = rob_val;
      else if (cdb_vld_i && int'(cdb_tag_i) == m_tag[idx]) v = cdb_data_i;
      else begin p = 1; q = m_tag[idx]; end
   endtask

   always @(posedge clk) begin
      bit acc;
      acc = iq_vld_i && exp_rdy();
      if (rst || flush_i) begin
         m_vld = 0;
         for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
      end else begin
         if (acc) begin
            lookup(iq_use_rs1_i, int'(iq_rs1_i), rf_rs1_data_i, rob_rd1_rdy_i, rob_rd1_data_i,
                   m_v1, m_p1, m_q1);
            lookup(iq_use_rs2_i, int'(iq_rs2_i), rf_rs2_data_i, rob_rd2_rdy_i, rob_rd2_data_i,
                   m_v2, m_p2, m_q2);
            m_vld = 1; m_rtag = int'(rob_alloc_tag_i); m_pay = iq_payload_i;
         end else if (m_vld && rs_rdy_i) begin
            m_vld = 0;
         end else if (m_vld && cdb_vld_i) begin
            if (m_p1 && int'(cdb_tag_i) == m_q1) begin m_v1 = cdb_data_i; m_p1 = 0; end
            if (m_p2 && int'(cdb_tag_i) == m_q2) begin m_v2 = cdb_data_i; m_p2 = 0; end
         end
         if (commit_vld_i && m_busy[commit_rd_i] && m_tag[commit_rd_i] == int'(commit_tag_i))
            m_busy[commit_rd_i] = 0;
         if (acc && iq_wr_rd_i && iq_rd_i != 0) begin
            m_busy[iq_rd_i] = 1;
            m_tag[iq_rd_i]  = int'(rob_alloc_tag_i);
         end
      end
   end

   always @(negedge clk) begin
      bit r;
      r = exp_rdy();
      check("iq_rdy", iq_rdy_o, r);
      check("alloc_vld", rob_alloc_vld_o, r && iq_vld_i);
      check("alloc_rd", rob_alloc_rd_o, iq_wr_rd_i ? iq_rd_i : 5'd0);
      check("rf_idx1", rf_rs1_idx_o, iq_rs1_i);
      check("rf_idx2", rf_rs2_idx_o, iq_rs2_i);
      if (!rst) begin
         check("rob_tag1", rob_rd1_tag_o, m_tag[iq_rs1_i]);
         check("rob_tag2", rob_rd2_tag_o, m_tag[iq_rs2_i]);
         check("rs_vld", rs_vld_o, m_vld);
         if (m_vld) begin
            check("rs_tag", rs_tag_o, m_rtag);
            check("rs_v1", rs_v1_o, m_v1);
            check("rs_v2", rs_v2_o, m_v2);
            check("rs_p1", rs_p1_o, m_p1);
            check("rs_p2", rs_p2_o, m_p2);
            if (m_p1) check("rs_q1", rs_q1_o, m_q1);
            if (m_p2) check("rs_q2", rs_q2_o, m_q2);
            check("rs_payload", rs_payload_o, m_pay);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic nx();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      iq_vld_i = 0; iq_rs1_i = 0; iq_rs2_i = 0; iq_rd_i = 0;
      iq_use_rs1_i = 0; iq_use_rs2_i = 0; iq_wr_rd_i = 0;
      rob_rd1_rdy_i = 0; rob_rd2_rdy_i = 0; rob_rd1_data_i = 0; rob_rd2_data_i = 0;
      cdb_vld_i = 0; cdb_tag_i = 0; cdb_data_i = 0;
      commit_vld_i = 0; commit_tag_i = 0; commit_rd_i = 0;
      flush_i = 0;
   endtask

   task automatic instr(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                        input logic [4:0] rd, input bit wr, input logic [TW-1:0] t);
      iq_vld_i = 1; iq_rs1_i = rs1; iq_use_rs1_i = u1; iq_rs2_i = rs2; iq_use_rs2_i = u2;
      iq_rd_i = rd; iq_wr_rd_i = wr; rob_alloc_tag_i = t;
      iq_payload_i = {32'hC0DE, 27'd0, rd, rs2, rs1, 28'd0, t};
   endtask

   initial begin
      idle();
      rst = 1; rob_alloc_rdy_i = 1; rs_rdy_i = 1; rob_alloc_tag_i = 0;
      rf_rs1_data_i = 0; rf_rs2_data_i = 0; iq_payload_i = 0;
      instr(5'd1, 1, 5'd2, 1, 5'd9, 1, 4'd1);
      nx(); @(negedge clk);
      check("reset_iq_rdy", iq_rdy_o, 1'b0);
      check("reset_alloc_vld", rob_alloc_vld_o, 1'b0);
      nx(); rst = 0; idle();
      @(negedge clk);
      check("reset_rs_vld", rs_vld_o, 1'b0);
      check("reset_rs_v1", rs_v1_o, 32'd0);
      check("reset_rs_payload", rs_payload_o, '0);

      // add x3,x1,x2 with an empty RAT
      nx(); instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 4'd2);
      rf_rs1_data_i = 32'd5; rf_rs2_data_i = 32'd7;
      @(negedge clk);
      check("add_alloc_vld", rob_alloc_vld_o, 1'b1);
      check("add_alloc_rd", rob_alloc_rd_o, 5'd3);
      nx(); idle();
      @(negedge clk);
      check("add_rs_vld", rs_vld_o, 1'b1);
      check("add_rs_tag", rs_tag_o, 4'd2);
      check("add_v1", rs_v1_o, 32'd5);
      check("add_v2", rs_v2_o, 32'd7);
      check("add_p", {rs_p1_o, rs_p2_o}, 2'b00);

      // RAW: A writes x5 (tag 0), B reads x5 while ROB entry 0 is not ready
      nx(); instr(5'd0, 0, 5'd0, 0, 5'd5, 1, 4'd0);
      nx(); idle(); instr(5'd5, 1, 5'd0, 0, 5'd6, 1, 4'd1);
      @(negedge clk);
      check("raw_rob_tag1", rob_rd1_tag_o, 4'd0);
      nx(); idle(); rs_rdy_i = 0;
      cdb_vld_i = 1; cdb_tag_i = 4'd0; cdb_data_i = 32'h2A;
      @(negedge clk);
      check("raw_p1", rs_p1_o, 1'b1);
      check("raw_q1", rs_q1_o, 4'd0);
      check("raw_tag", rs_tag_o, 4'd1);

      // held packet captures, then stays stable under backpressure
      nx(); idle(); instr(5'd5, 1, 5'd0, 0, 5'd7, 1, 4'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_v1", rs_v1_o, 32'h2A);
         check("hold_p1", rs_p1_o, 1'b0);
         check("hold_tag", rs_tag_o, 4'd1);
         check("hold_iq_rdy", iq_rdy_o, 1'b0);
         nx();
      end
      // same-cycle CDB at accept resolves directly
      rs_rdy_i = 1; cdb_vld_i = 1; cdb_tag_i = 4'd0; cdb_data_i = 32'h2A;
      @(negedge clk);
      check("cdb_acc_alloc", rob_alloc_vld_o, 1'b1);
      nx(); idle();
      @(negedge clk);
      check("cdb_acc_tag", rs_tag_o, 4'd3);
      check("cdb_acc_v1", rs_v1_o, 32'h2A);
      check("cdb_acc_p1", rs_p1_o, 1'b0);

      // collision: commit of x7/tag3 and new x7 writer (tag 4) in one cycle
      nx(); instr(5'd0, 0, 5'd0, 0, 5'd7, 1, 4'd4);
      commit_vld_i = 1; commit_tag_i = 4'd3; commit_rd_i = 5'd7;
      nx(); idle(); instr(5'd7, 1, 5'd0, 0, 5'd0, 0, 4'd5);
      commit_vld_i = 1; commit_tag_i = 4'd3; commit_rd_i = 5'd7;
      @(negedge clk);
      check("coll_rob_tag1", rob_rd1_tag_o, 4'd4);
      nx(); idle(); instr(5'd7, 1, 5'd6, 1, 5'd0, 0, 4'd6);
      rob_rd2_rdy_i = 1; rob_rd2_data_i = 32'h77;
      @(negedge clk);
      check("coll_p1", rs_p1_o, 1'b1);
      check("coll_q1", rs_q1_o, 4'd4);
      nx(); idle(); rs_rdy_i = 0;
      @(negedge clk);
      check("stale_p1", rs_p1_o, 1'b1);
      check("stale_q1", rs_q1_o, 4'd4);
      check("robval_v2", rs_v2_o, 32'h77);

      // flush with a held packet and x5 still busy
      nx(); instr(5'd5, 1, 5'd0, 0, 5'd8, 1, 4'd7); flush_i = 1;
      @(negedge clk);
      check("flush_iq_rdy", iq_rdy_o, 1'b0);
      check("flush_alloc", rob_alloc_vld_o, 1'b0);
      nx(); flush_i = 0; rs_rdy_i = 1; rf_rs1_data_i = 32'h1234;
      @(negedge clk);
      check("flush_rs_vld", rs_vld_o, 1'b0);
      nx(); idle();
      @(negedge clk);
      check("flush_v1", rs_v1_o, 32'h1234);
      check("flush_p1", rs_p1_o, 1'b0);

      // x0 is never renamed and always reads as zero
      nx(); instr(5'd0, 0, 5'd0, 0, 5'd0, 1, 4'd8);
      @(negedge clk);
      check("x0_alloc_rd", rob_alloc_rd_o, 5'd0);
      nx(); idle(); instr(5'd0, 1, 5'd0, 0, 5'd0, 0, 4'd9); rf_rs1_data_i = 32'hFFFF_FFFF;
      nx(); idle();
      @(negedge clk);
      check("x0_v1", rs_v1_o, 32'd0);
      check("x0_p1", rs_p1_o, 1'b0);

      // ROB full with empty output register
      nx(); rob_alloc_rdy_i = 0; instr(5'd1, 1, 5'd2, 1, 5'd4, 1, 4'd10);
      @(negedge clk);
      check("robfull_iq_rdy", iq_rdy_o, 1'b0);
      check("robfull_alloc", rob_alloc_vld_o, 1'b0);
      nx(); idle(); rob_alloc_rdy_i = 1;
      nx(); nx();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
